// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_arb_pkg: shared sizes, state encoding and index type for mux8_rr_arbiter.
`default_nettype none

package mux8_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
    typedef logic [IDX_W-1:0] arb_idx_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input arb_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: request/grant/select bundle between requesters and the arbiter.
// Carries the lock vector only when MUX8_ARB_LOCK_EN is defined.
`default_nettype none

interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
`ifdef MUX8_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock;
`endif
    logic [NUM_REQ-1:0] grant;
    logic               sel0;
    logic               sel1;
    logic               sel2;
    logic               busy;

`ifdef MUX8_ARB_LOCK_EN
    modport master (output req, output lock, input grant, input sel0, input sel1, input sel2, input busy);
    modport slave  (input req, input lock, output grant, output sel0, output sel1, output sel2, output busy);
`else
    modport master (output req, input grant, input sel0, input sel1, input sel2, input busy);
    modport slave  (input req, output grant, output sel0, output sel1, output sel2, output busy);
`endif

endinterface

`default_nettype wire

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: first set request at or after start_i, wrapping modulo 8.
// With excl_i set, the index just before start_i (the current owner) is skipped.
`default_nettype none

module rr_pick8
    import mux8_arb_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire arb_idx_t           start_i,
    input  wire logic               excl_i,
    output logic                    found_o,
    output arb_idx_t                idx_o
);

    logic [NUM_REQ-1:0] w_masked;
    arb_idx_t           w_cand;

    always_comb begin
        w_masked = req_i;
        if (excl_i) begin
            w_masked[start_i - arb_idx_t'(1)] = 1'b0;
        end
        found_o = 1'b0;
        idx_o   = start_i;
        w_cand  = start_i;
        // Scan from the far end so the nearest candidate overwrites last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = start_i + arb_idx_t'(k);
            if (w_masked[w_cand]) begin
                found_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of the shared 8:1 select tree with a bounded hold time.
// Optional MUX8_ARB_LOCK_EN lets the owner suppress forced rotation via lock.
`default_nettype none

module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mux8_rr_arbiter_if.slave  bus
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t          state_q;
    arb_idx_t            own_idx_q;
    arb_idx_t            last_idx_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [NUM_REQ-1:0]  grant_q;

    arb_idx_t            start_d;
    logic                pick_found_d;
    arb_idx_t            pick_idx_d;
    logic                owner_req_d;
    logic                locked_d;

    assign start_d     = last_idx_q + arb_idx_t'(1);
    assign owner_req_d = bus.req[own_idx_q];
`ifdef MUX8_ARB_LOCK_EN
    assign locked_d    = owner_req_d & bus.lock[own_idx_q];
`else
    assign locked_d    = 1'b0;
`endif

    // While owning, the owner is last_idx_q and must not be picked as its own successor.
    rr_pick8 u_pick (
        .req_i   (bus.req),
        .start_i (start_d),
        .excl_i  (state_q == ARB_OWN),
        .found_o (pick_found_d),
        .idx_o   (pick_idx_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            own_idx_q  <= '0;
            last_idx_q <= arb_idx_t'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found_d) begin
                        state_q    <= ARB_OWN;
                        own_idx_q  <= pick_idx_d;
                        last_idx_q <= pick_idx_d;
                        hold_cnt_q <= '0;
                        grant_q    <= idx_onehot(pick_idx_d);
                    end
                end
                ARB_OWN: begin
                    if (!owner_req_d || (!locked_d && pick_found_d && hold_cnt_q == HOLD_LAST)) begin
                        if (pick_found_d) begin
                            own_idx_q  <= pick_idx_d;
                            last_idx_q <= pick_idx_d;
                            hold_cnt_q <= '0;
                            grant_q    <= idx_onehot(pick_idx_d);
                        end else begin
                            state_q    <= ARB_IDLE;
                            hold_cnt_q <= '0;
                            grant_q    <= '0;
                        end
                    end else if (!locked_d && hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = |grant_q;
    assign bus.sel0  = own_idx_q[0];
    assign bus.sel1  = own_idx_q[1];
    assign bus.sel2  = own_idx_q[2];

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and random stimulus against a tenure-based round-robin model.
`default_nettype none

module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req_v = 8'h00;
    logic [7:0] lock_v = 8'h00;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Model: owner (-1 = none), last granted index, cycles owned so far, select lines.
    int m_owner = -1;
    int m_last  = 7;
    int m_ten   = 0;
    int m_sel   = 0;

    mux8_rr_arbiter_if bus();
    assign bus.req = req_v;
`ifdef MUX8_ARB_LOCK_EN
    assign bus.lock = lock_v;
`endif

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 7;
        m_ten   = 0;
        m_sel   = 0;
    endfunction

    function automatic int next_req(input logic [7:0] r, input int excl);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (m_last + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic void take(input int i);
        m_owner = i;
        m_last  = i;
        m_sel   = i;
        m_ten   = 1;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic [7:0] l);
        int  nxt;
        bit  locked;
        nxt = next_req(r, m_owner);
        locked = 1'b0;
`ifdef MUX8_ARB_LOCK_EN
        if (m_owner >= 0) locked = r[m_owner] && l[m_owner];
`else
        if (l != l) locked = 1'b1;
`endif
        if (m_owner < 0) begin
            if (nxt >= 0) take(nxt);
        end else if (!r[m_owner]) begin
            if (nxt >= 0) take(nxt);
            else m_owner = -1;
        end else if (locked) begin
            m_ten = m_ten;
        end else if (nxt >= 0 && m_ten >= MAX_HOLD) begin
            take(nxt);
        end else if (m_ten < 1000) begin
            m_ten++;
        end
    endfunction

    task automatic step(input logic [7:0] r, input logic [7:0] l);
        exp_t e;
        @(negedge clk);
        req_v  = r;
        lock_v = l;
        model_step(r, l);
        e.grant = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e.sel   = 3'(m_sel);
        exp_q.push_back(e);
    endtask

    // Monitor: compares each registered response just after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", int'(bus.grant), int'(e.grant));
                chk("sel", int'({bus.sel2, bus.sel1, bus.sel0}), int'(e.sel));
                chk("busy", int'(bus.busy), int'(e.grant != 8'h00));
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic [7:0] l;

        // Reset with every requester active.
        req_v = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", int'(bus.grant), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_sel", int'({bus.sel2, bus.sel1, bus.sel0}), 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        step(8'hFF, 8'h00);
        step(8'h00, 8'h00);

        // Single requester, then release keeps the select lines.
        repeat (10) step(8'h20, 8'h00);
        repeat (2) step(8'h00, 8'h00);

        // Fairness between 0 and 7.
        repeat (16) step(8'h81, 8'h00);
        step(8'h00, 8'h00);

        // Handoff from owner 3 directly to 6.
        repeat (2) step(8'h08, 8'h00);
        step(8'h4A, 8'h00);
        repeat (2) step(8'h42, 8'h00);

        // Asynchronous reset between edges while requester 2 owns.
        repeat (3) step(8'h04, 8'h00);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_grant", int'(bus.grant), 0);
        chk("async_busy", int'(bus.busy), 0);
        #1;
        reset_n = 1'b1;
        model_reset();
        repeat (2) step(8'h04, 8'h00);

`ifdef MUX8_ARB_LOCK_EN
        repeat (12) step(8'h03, 8'h01);
        repeat (6) step(8'h03, 8'h00);
`endif

        // Random traffic with persistent requests.
        r = 8'h00;
        l = 8'h00;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
`ifdef MUX8_ARB_LOCK_EN
            l = 8'($urandom);
`endif
            step(r, l);
        end
        repeat (2) step(8'h00, 8'h00);

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
